// File: rtl/edge_event_detector_pkg.sv
// Shared edge-mode encoding and the mode/direction match rule used by
// every channel of edge_event_detector.
package edge_event_detector_pkg;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  // newLevel is the level being accepted; the edge direction follows from it.
  function automatic logic edgeMatches(input logic [1:0] mode, input logic newLevel);
    logic match;
    match = 1'b0;
    case (edge_mode_e'(mode))
      EDGE_RISE: match = newLevel;
      EDGE_FALL: match = ~newLevel;
      EDGE_BOTH: match = 1'b1;
      default:   match = 1'b0;
    endcase
    return match;
  endfunction

endpackage

// File: rtl/edge_event_detector_debounce_chan.sv
// One input channel: synchroniser, debounce counter, accepted level,
// mode-qualified one-cycle pulse and a sticky event flag with clear.
module debounce_chan
  import edge_event_detector_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_signal,
  input  logic [1:0] i_mode,
  input  logic       i_clr,
  output logic       o_level,
  output logic       o_pulse,
  output logic       o_flag
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_syncChain;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_pulse;
  logic                   r_flag;

  logic w_syncOut;
  logic w_differs;
  logic w_accept;
  logic w_fire;

  assign w_syncOut = r_syncChain[SYNC_STAGES-1];
  assign w_differs = (w_syncOut != r_level);
  assign w_accept  = w_differs && (r_cnt == CNT_LAST);
  // Mode is looked at only on the accepting cycle, so changing it never pulses.
  assign w_fire    = w_accept && edgeMatches(i_mode, w_syncOut);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_syncChain <= '0;
    end else begin
      r_syncChain <= {r_syncChain[SYNC_STAGES-2:0], i_signal};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (!w_differs) begin
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_level <= w_syncOut;
      r_cnt   <= '0;
    end else begin
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  // The flag is set on the same edge the pulse is registered; set beats clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pulse <= 1'b0;
      r_flag  <= 1'b0;
    end else begin
      r_pulse <= w_fire;
      if (w_fire) begin
        r_flag <= 1'b1;
      end else if (i_clr) begin
        r_flag <= 1'b0;
      end
    end
  end

  assign o_level = r_level;
  assign o_pulse = r_pulse;
  assign o_flag  = r_flag;

endmodule

// File: rtl/edge_event_detector.sv
// Multi-channel debounced edge detector: one debounce_chan per input plus
// an OR of the sticky flags for the alarm FSM.
module edge_event_detector
  import edge_event_detector_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [CHANNELS-1:0]   i_signal,
  input  logic [2*CHANNELS-1:0] i_mode,
  input  logic [CHANNELS-1:0]   i_clr,
  output logic [CHANNELS-1:0]   o_level,
  output logic [CHANNELS-1:0]   o_pulse,
  output logic [CHANNELS-1:0]   o_flag,
  output logic                  o_any
);

  logic [CHANNELS-1:0] w_level;
  logic [CHANNELS-1:0] w_pulse;
  logic [CHANNELS-1:0] w_flag;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    debounce_chan #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_signal (i_signal[c]),
      .i_mode   (i_mode[2*c +: 2]),
      .i_clr    (i_clr[c]),
      .o_level  (w_level[c]),
      .o_pulse  (w_pulse[c]),
      .o_flag   (w_flag[c])
    );
  end

  assign o_level = w_level;
  assign o_pulse = w_pulse;
  assign o_flag  = w_flag;
  assign o_any   = |w_flag;

endmodule

// File: tb/tb_edge_event_detector.sv
// Scoreboard bench for edge_event_detector: stimulus queues expected pulses,
// a negedge monitor matches every observed pulse against the queue.
module tb_edge_event_detector;

  localparam int CH  = 4;
  localparam int LAT = 6;

  typedef struct {
    int   ch;
    int   cyc;
    logic lvl;
  } expEvent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] sig = '0;
  logic [2*CH-1:0] mode = '0;
  logic [CH-1:0] clr = '0;
  logic [CH-1:0] level;
  logic [CH-1:0] pulse;
  logic [CH-1:0] flag;
  logic          any;

  int        cycleCount = 0;
  int        checks     = 0;
  int        failures   = 0;
  expEvent_t expQ[$];

  edge_event_detector #(
    .CHANNELS        (CH),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_signal (sig),
    .i_mode   (mode),
    .i_clr    (clr),
    .o_level  (level),
    .o_pulse  (pulse),
    .o_flag   (flag),
    .o_any    (any)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, actual, expected, cycleCount);
    end
  endtask

  // Drives one channel; when a pulse is expected it is due LAT edges from now.
  task automatic applyStimulus(input int ch, input logic val, input logic expectPulse);
    expEvent_t e;
    sig[ch] = val;
    if (expectPulse) begin
      e.ch  = ch;
      e.cyc = cycleCount + LAT;
      e.lvl = val;
      expQ.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (pulse[c] === 1'b1) begin
        int idx;
        idx = -1;
        for (int i = 0; i < expQ.size(); i++) begin
          if (idx < 0 && expQ[i].ch == c) idx = i;
        end
        if (idx < 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpectedPulse ch=%0d actual=1 expected=0 (cycle %0d)", c, cycleCount);
        end else begin
          checks++;
          if (expQ[idx].cyc != cycleCount) begin
            failures++;
            $display("[TB] FAIL pulseCycle ch=%0d actual=%0d expected=%0d", c, cycleCount, expQ[idx].cyc);
          end
          checks++;
          if (level[c] !== expQ[idx].lvl) begin
            failures++;
            $display("[TB] FAIL pulseLevel ch=%0d actual=%b expected=%b", c, level[c], expQ[idx].lvl);
          end
          expQ.delete(idx);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    tick(3);
    checkOutput("resetLevel", 8'(level), 8'h0);
    checkOutput("resetPulse", 8'(pulse), 8'h0);
    checkOutput("resetFlag",  8'(flag),  8'h0);
    checkOutput("resetAny",   8'(any),   8'h0);
    rst  = 1'b0;
    mode = 8'b00_10_01_01;
    tick(1);

    $display("[TB] ch0 rise step");
    applyStimulus(0, 1'b1, 1'b1);
    tick(20);
    checkOutput("ch0Level", 8'(level[0]), 8'h1);
    checkOutput("ch0Flag",  8'(flag[0]),  8'h1);
    checkOutput("anyAfterCh0", 8'(any),  8'h1);

    $display("[TB] ch1 three-cycle glitch");
    applyStimulus(1, 1'b1, 1'b0);
    tick(3);
    applyStimulus(1, 1'b0, 1'b0);
    tick(12);
    checkOutput("ch1GlitchLevel", 8'(level[1]), 8'h0);
    checkOutput("ch1GlitchFlag",  8'(flag[1]),  8'h0);

    $display("[TB] ch2 fall-only then both");
    applyStimulus(2, 1'b1, 1'b0);
    tick(10);
    checkOutput("ch2LevelHigh", 8'(level[2]), 8'h1);
    checkOutput("ch2FlagNoRise", 8'(flag[2]), 8'h0);
    applyStimulus(2, 1'b0, 1'b1);
    tick(10);
    mode[5:4] = 2'b11;
    tick(3);
    applyStimulus(2, 1'b1, 1'b1);
    tick(10);
    applyStimulus(2, 1'b0, 1'b1);
    tick(10);
    checkOutput("ch2LevelLow", 8'(level[2]), 8'h0);
    checkOutput("ch2Flag",     8'(flag[2]),  8'h1);

    $display("[TB] ch3 mode none");
    applyStimulus(3, 1'b1, 1'b0);
    tick(10);
    checkOutput("ch3Level", 8'(level[3]), 8'h1);
    checkOutput("ch3Flag",  8'(flag[3]),  8'h0);

    $display("[TB] flag clear versus new event");
    clr[2] = 1'b1;
    tick(1);
    clr[2] = 1'b0;
    checkOutput("ch2Cleared", 8'(flag[2]), 8'h0);
    checkOutput("anyWithCh0", 8'(any),     8'h1);
    applyStimulus(0, 1'b0, 1'b0);
    tick(10);
    applyStimulus(0, 1'b1, 1'b1);
    tick(5);
    clr[0] = 1'b1;
    tick(1);
    checkOutput("ch0SetBeatsClear", 8'(flag[0]), 8'h1);
    tick(1);
    checkOutput("ch0ClearedFlag", 8'(flag[0]), 8'h0);
    checkOutput("anyFalls",       8'(any),     8'h0);
    tick(1);
    clr[0] = 1'b0;
    checkOutput("ch0ClearIdle", 8'(flag[0]), 8'h0);

    $display("[TB] reset with inputs high, ch1 mid-count");
    mode = 8'b01_01_01_01;
    applyStimulus(1, 1'b1, 1'b0);
    tick(4);
    sig = 4'hF;
    rst = 1'b1;
    tick(1);
    checkOutput("midResetLevel", 8'(level), 8'h0);
    checkOutput("midResetFlag",  8'(flag),  8'h0);
    tick(2);
    checkOutput("midResetPulse", 8'(pulse), 8'h0);
    checkOutput("midResetAny",   8'(any),   8'h0);
    rst = 1'b0;
    for (int c = 0; c < CH; c++) applyStimulus(c, 1'b1, 1'b1);
    tick(5);
    checkOutput("postResetEarly", 8'(level), 8'h0);
    tick(1);
    checkOutput("postResetLevel", 8'(level), 8'hF);
    checkOutput("postResetFlag",  8'(flag),  8'hF);
    checkOutput("postResetAny",   8'(any),   8'h1);
    tick(5);

    checkOutput("pendingEvents", 8'(expQ.size()), 8'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
